noc_output_arbiter: RTL and testbench

Per-output-port wormhole arbiter and flit register for the NoC router. It sits directly downstream of `priority_encoder` and produces the one-hot grant that steers the crossbar. It selects one input with a round-robin scheme built on `priority_encoder`, locks that input for the whole packet (head to tail), and moves flits into a single registered output stage with valid/ready handshaking on both sides.

---
 rtl/noc_pkg.sv | 13 +
 rtl/priority_encoder.sv | 14 +
 rtl/noc_output_arbiter.sv | 149 ++++++++++++++
 tb/tb_noc_output_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: arbiter state encoding and the default flit format.
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NOC_FLIT_WIDTH = 64;

  typedef logic [NOC_FLIT_WIDTH-1:0] flit_t;

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: one-hot grant of the lowest set request bit.
module priority_encoder #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));
  assign valid = |req;

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin head selection, packet lock
// from head to tail, and a single registered output stage with valid/ready.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  input  logic [NUM_INPUTS-1:0]          in_head,
  input  logic [NUM_INPUTS-1:0]          in_tail,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit,
  output logic [NUM_INPUTS-1:0]          in_ready,
  output logic                           out_valid,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_tail,
  input  logic                           out_ready,
  output logic [NUM_INPUTS-1:0]          grant_onehot,
  output logic                           locked
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [NUM_INPUTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (oh[i]) idx |= IDX_W'(i);
    end
    return idx;
  endfunction

  arb_state_e              state_reg, state_next;
  logic [IDX_W-1:0]        last_grant_reg, last_grant_next;
  logic [NUM_INPUTS-1:0]   grant_reg, grant_next;
  logic                    out_valid_reg;
  logic [FLIT_WIDTH-1:0]   out_flit_reg;
  logic                    out_tail_reg;

  logic [NUM_INPUTS-1:0]   req, mask;
  logic [NUM_INPUTS-1:0]   masked_grant, all_grant, idle_pick;
  logic                    masked_valid, all_valid;
  logic                    acc, xfer;
  logic [IDX_W-1:0]        sel_idx;
  logic [FLIT_WIDTH-1:0]   flit_arr [NUM_INPUTS];
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_tail;

  assign req = in_valid & in_head;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
      assign mask[gi]     = (gi > int'(last_grant_reg));
      assign flit_arr[gi] = in_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

  priority_encoder #(.WIDTH(NUM_INPUTS)) u_pe_masked (
    .req   (req & mask),
    .grant (masked_grant),
    .valid (masked_valid)
  );

  priority_encoder #(.WIDTH(NUM_INPUTS)) u_pe_all (
    .req   (req),
    .grant (all_grant),
    .valid (all_valid)
  );

  // Wrap to the unmasked search only when nothing sits above the pointer.
  assign idle_pick = masked_valid ? masked_grant : (all_valid ? all_grant : '0);
  assign acc       = !out_valid_reg || out_ready;

  always_comb begin
    in_ready = '0;
    if (acc) begin
      in_ready = (state_reg == IDLE) ? idle_pick : grant_reg;
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign sel_idx  = onehot2idx(in_ready);
  assign sel_flit = flit_arr[sel_idx];
  assign sel_tail = in_tail[sel_idx];

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          last_grant_next = sel_idx;
          if (!sel_tail) begin
            state_next = LOCKED;
            grant_next = in_ready;
          end
        end
      end
      LOCKED: begin
        // Owner's head bit is ignored here; only the tail ends the packet.
        if (xfer && sel_tail) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_INPUTS - 1);
      grant_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
      out_tail_reg  <= 1'b0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_flit_reg  <= sel_flit;
      out_tail_reg  <= sel_tail;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_flit     = out_flit_reg;
  assign out_tail     = out_tail_reg;
  assign grant_onehot = grant_reg;
  assign locked       = (state_reg == LOCKED);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter with a flit scoreboard on the output.
module tb_noc_output_arbiter;

  localparam int N = 5;
  localparam int W = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_head;
  logic [N-1:0]   in_tail;
  logic [N*W-1:0] in_flit;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_flit;
  logic           out_tail;
  logic           out_ready;
  logic [N-1:0]   grant_onehot;
  logic           locked;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] sb [$];

  noc_output_arbiter #(.NUM_INPUTS(N), .FLIT_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_head      (in_head),
    .in_tail      (in_tail),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_tail     (out_tail),
    .out_ready    (out_ready),
    .grant_onehot (grant_onehot),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic h, input logic t, input logic [W-1:0] f);
    in_valid[i]        = v;
    in_head[i]         = h;
    in_tail[i]         = t;
    in_flit[i*W +: W]  = f;
  endtask

  // One clock: check combinational/registered outputs at negedge, score the
  // output flit, push flits the bench expects to be accepted, then advance.
  task automatic cycle(input logic [N-1:0] er, input logic el, input logic [N-1:0] eg, input string tag);
    logic [W:0] e;
    @(negedge clk);
    check({tag, "_in_ready"}, W'(in_ready), W'(er));
    check({tag, "_locked"}, W'(locked), W'(el));
    check({tag, "_grant"}, W'(grant_onehot), W'(eg));
    if (!out_ready && sb.size() > 0) begin
      e = sb[0];
      check({tag, "_stall_valid"}, W'(out_valid), W'(1));
      check({tag, "_stall_flit"}, out_flit, e[W-1:0]);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check({tag, "_extra_out"}, W'(out_valid), W'(0));
      end else begin
        e = sb.pop_front();
        check({tag, "_out_flit"}, out_flit, e[W-1:0]);
        check({tag, "_out_tail"}, W'(out_tail), W'(e[W]));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (er[i] && in_valid[i]) sb.push_back({in_tail[i], in_flit[i*W +: W]});
    end
    $display("step %s: in_ready=%b locked=%b grant=%b out_valid=%b out_flit=%0h",
             tag, in_ready, locked, grant_onehot, out_valid, out_flit);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [N-1:0] er;
    int w;
    rst       = 1'b1;
    in_valid  = '0;
    in_head   = '0;
    in_tail   = '0;
    in_flit   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_flit", out_flit, W'(0));
    check("rst_out_tail", W'(out_tail), W'(0));
    check("rst_grant", W'(grant_onehot), W'(0));
    check("rst_locked", W'(locked), W'(0));
    rst = 1'b0;

    // Reset priority: inputs 0 and 3 together, 0 wins first.
    drive(0, 1, 1, 1, 64'h0000_0000_0000_00A0);
    drive(3, 1, 1, 1, 64'h0000_0000_0000_03A0);
    cycle(5'b00001, 1'b0, 5'b00000, "rp0");
    drive(0, 0, 0, 0, '0);
    cycle(5'b01000, 1'b0, 5'b00000, "rp3");
    drive(3, 0, 0, 0, '0);
    cycle(5'b00000, 1'b0, 5'b00000, "rp_drain");

    // Round-robin fairness from a fresh pointer.
    pulse_reset();
    for (int i = 0; i < N; i++) drive(i, 1, 1, 1, W'(64'h1000 + i * 16));
    for (int k = 0; k < 6; k++) begin
      w  = k % N;
      er = '0;
      er[w] = 1'b1;
      cycle(er, 1'b0, 5'b00000, $sformatf("rr%0d", k));
      drive(w, 1, 1, 1, W'(64'h1000 + w * 16 + k + 1));
    end
    for (int i = 0; i < N; i++) drive(i, 0, 0, 0, '0);
    cycle(5'b00000, 1'b0, 5'b00000, "rr_drain");

    // Wormhole lock: input 2 packet A0..A3, input 1 head waits.
    drive(2, 1, 1, 0, 64'hA0);
    cycle(5'b00100, 1'b0, 5'b00000, "wl_a0");
    drive(2, 1, 0, 0, 64'hA1);
    drive(1, 1, 1, 1, 64'hB0);
    cycle(5'b00100, 1'b1, 5'b00100, "wl_a1");
    drive(2, 1, 1, 0, 64'hA2);
    cycle(5'b00100, 1'b1, 5'b00100, "wl_a2");
    drive(2, 1, 0, 1, 64'hA3);
    cycle(5'b00100, 1'b1, 5'b00100, "wl_a3");
    drive(2, 0, 0, 0, '0);
    cycle(5'b00010, 1'b0, 5'b00000, "wl_b0");
    drive(1, 0, 0, 0, '0);
    cycle(5'b00000, 1'b0, 5'b00000, "wl_drain");

    // Backpressure mid-packet on input 3.
    drive(3, 1, 1, 0, 64'hC0);
    cycle(5'b01000, 1'b0, 5'b00000, "bp_c0");
    drive(3, 1, 0, 0, 64'hC1);
    cycle(5'b01000, 1'b1, 5'b01000, "bp_c1");
    drive(3, 1, 0, 0, 64'hC2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle(5'b00000, 1'b1, 5'b01000, $sformatf("bp_stall%0d", k));
    out_ready = 1'b1;
    cycle(5'b01000, 1'b1, 5'b01000, "bp_c2");
    drive(3, 1, 0, 1, 64'hC3);
    cycle(5'b01000, 1'b1, 5'b01000, "bp_c3");
    drive(3, 0, 0, 0, '0);
    cycle(5'b00000, 1'b0, 5'b00000, "bp_drain");

    // Stray body flit in IDLE never accepted.
    drive(4, 1, 0, 0, 64'hDEAD);
    for (int k = 0; k < 4; k++) cycle(5'b00000, 1'b0, 5'b00000, $sformatf("stray%0d", k));
    check("stray_out_valid", W'(out_valid), W'(0));
    drive(4, 0, 0, 0, '0);

    // Reset mid-packet drops lock and buffered flit asynchronously.
    drive(1, 1, 1, 0, 64'hD0);
    cycle(5'b00010, 1'b0, 5'b00000, "mr_d0");
    drive(1, 1, 0, 0, 64'hD1);
    cycle(5'b00010, 1'b1, 5'b00010, "mr_d1");
    rst = 1'b1;
    #1;
    check("mr_out_valid", W'(out_valid), W'(0));
    check("mr_locked", W'(locked), W'(0));
    check("mr_grant", W'(grant_onehot), W'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 1, 1, 64'hE0);
    drive(4, 1, 1, 1, 64'hE4);
    cycle(5'b00001, 1'b0, 5'b00000, "mr_prio0");
    drive(0, 0, 0, 0, '0);
    cycle(5'b10000, 1'b0, 5'b00000, "mr_prio4");
    drive(4, 0, 0, 0, '0);
    cycle(5'b00000, 1'b0, 5'b00000, "mr_drain0");
    cycle(5'b00000, 1'b0, 5'b00000, "mr_drain1");

    check("sb_empty", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
